// File: rtl/reg_file_wb_pkg.sv
// Shared definitions for the write-back register file: default widths,
// the two-state init/run FSM encoding and the hard-wired zero register.
package reg_file_wb_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 0;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/reg_file_wb_wb_decoder.sv
// Write-back address decoder: turns the destination register number into a
// one-hot write select. Register 0 is never selected, and nothing is selected
// unless the register file is ready.
module wb_decoder
  import reg_file_wb_pkg::*;
#(
  parameter int ADDR_W = reg_file_wb_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0]      writeAddr_i,
  input  logic                   writeEnable_i,
  input  logic                   ready_i,
  output logic [(2**ADDR_W)-1:0] wsel_o
);

  // One-hot select, gated by strobe and ready, with the zero register masked
  always_comb begin
    wsel_o = '0;
    if (writeEnable_i && ready_i) begin
      wsel_o[writeAddr_i] = 1'b1;
    end
    wsel_o[ZERO_REG] = 1'b0;
  end

endmodule

// File: rtl/reg_file_wb.sv
// Two-read, one-write register file for the write-back stage. After reset a
// sweep zeroes every register (CLEAR), then normal operation begins (RUN).
// Reads are combinational with same-cycle write-to-read bypass; register 0
// always reads zero.
module reg_file_wb
  import reg_file_wb_pkg::*;
#(
  parameter int DATA_W = reg_file_wb_pkg::DATA_W,
  parameter int ADDR_W = reg_file_wb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              writeEnable,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readAddr1,
  input  logic [ADDR_W-1:0] readAddr2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic              ready
);

  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              run;
  logic [NREGS-1:0]  wsel;
  logic [NREGS-1:0]  clr_sel;
  logic [DATA_W-1:0] regs_q [NREGS];

  // Reset is folded in combinationally so outputs go quiet the moment it rises,
  // and any write presented in a reset cycle is dropped.
  assign run   = (state_q == RUN) && !reset;
  assign ready = run;

  // Sweep counter advances every CLEAR cycle; last address hands over to RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_ADDR) begin
        state_d = RUN;
      end
    end
  end

  // FSM and sweep counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep select: the register currently being zeroed
  always_comb begin
    clr_sel = '0;
    if ((state_q == CLEAR) && !reset) begin
      clr_sel[cnt_q] = 1'b1;
    end
  end

  wb_decoder #(
    .ADDR_W (ADDR_W)
  ) u_wb_decoder (
    .writeAddr_i   (writeAddr),
    .writeEnable_i (writeEnable),
    .ready_i       (run),
    .wsel_o        (wsel)
  );

  // Register array: sweep zeroing in CLEAR, decoded write-back in RUN
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (clr_sel[i]) begin
        regs_q[i] <= '0;
      end else if (wsel[i]) begin
        regs_q[i] <= writeData;
      end
    end
  end

  // Read port 1: zero when not ready or addressing r0, else bypass or array
  always_comb begin
    readData1 = '0;
    if (run && (readAddr1 != ZERO_ADDR)) begin
      if (writeEnable && (writeAddr == readAddr1)) begin
        readData1 = writeData;
      end else begin
        readData1 = regs_q[readAddr1];
      end
    end
  end

  // Read port 2: same selection as port 1, so shared addresses agree
  always_comb begin
    readData2 = '0;
    if (run && (readAddr2 != ZERO_ADDR)) begin
      if (writeEnable && (writeAddr == readAddr2)) begin
        readData2 = writeData;
      end else begin
        readData2 = regs_q[readAddr2];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed testbench for reg_file_wb: init sweep timing, write/read, zero
// register, bypass, writes ignored during the sweep and mid-run reset.
module tb_reg_file_wb;

  logic        clk;
  logic        reset;
  logic        writeEnable;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic [4:0]  readAddr1;
  logic [4:0]  readAddr2;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic        ready;

  int n_pass  = 0;
  int n_total = 0;

  reg_file_wb #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .writeEnable (writeEnable),
    .writeAddr   (writeAddr),
    .writeData   (writeData),
    .readAddr1   (readAddr1),
    .readAddr2   (readAddr2),
    .readData1   (readData1),
    .readData2   (readData2),
    .ready       (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count cycles of ready low after a reset edge, optionally injecting a
  // write to r3 during sweep cycle 10 and checking reads are forced to 0.
  task automatic count_sweep(input bit inject, output int low_cycles);
    low_cycles = 0;
    while (!ready && low_cycles < 100) begin
      if (inject && low_cycles == 10) begin
        writeEnable = 1'b1;
        writeAddr   = 5'd3;
        writeData   = 32'hFFFF_FFFF;
        readAddr1   = 5'd3;
        readAddr2   = 5'd3;
        #1;
        check("clear_rd1_forced0", readData1, 32'h0);
        check("clear_rd2_forced0", readData2, 32'h0);
      end
      step();
      writeEnable = 1'b0;
      low_cycles++;
    end
  endtask

  int lows;

  initial begin
    reset       = 1'b1;
    writeEnable = 1'b0;
    writeAddr   = '0;
    writeData   = '0;
    readAddr1   = 5'd5;
    readAddr2   = 5'd6;

    // Reset held for one edge
    step();
    check("reset_ready", {31'b0, ready}, 32'h0);
    check("reset_rd1", readData1, 32'h0);
    reset = 1'b0;

    // Sweep: 32 cycles of ready low, then ready
    count_sweep(1'b1, lows);
    check("sweep_low_cycles", lows, 32);
    check("ready_after_sweep", {31'b0, ready}, 32'h1);

    // Every register reads zero, including r3 written during CLEAR
    for (int a = 0; a < 32; a++) begin
      readAddr1 = 5'(a);
      readAddr2 = 5'(31 - a);
      #1;
      check($sformatf("init_p1_r%0d", a), readData1, 32'h0);
      check($sformatf("init_p2_r%0d", 31 - a), readData2, 32'h0);
    end

    // Write r9 then read it back next cycle; r10 unaffected
    writeEnable = 1'b1;
    writeAddr   = 5'd9;
    writeData   = 32'hDEAD_BEEF;
    readAddr1   = 5'd1;
    readAddr2   = 5'd2;
    step();
    writeEnable = 1'b0;
    readAddr1   = 5'd9;
    readAddr2   = 5'd10;
    #1;
    check("wr_r9_p1", readData1, 32'hDEAD_BEEF);
    check("wr_r10_p2", readData2, 32'h0);

    // Write to r0 is discarded, same and next cycle
    writeEnable = 1'b1;
    writeAddr   = 5'd0;
    writeData   = 32'h1234_5678;
    readAddr1   = 5'd0;
    readAddr2   = 5'd0;
    #1;
    check("r0_same_p1", readData1, 32'h0);
    check("r0_same_p2", readData2, 32'h0);
    step();
    writeEnable = 1'b0;
    #1;
    check("r0_next_p1", readData1, 32'h0);
    check("r0_next_p2", readData2, 32'h0);

    // Bypass on both ports, then stored value persists
    writeEnable = 1'b1;
    writeAddr   = 5'd17;
    writeData   = 32'hA5A5_A5A5;
    readAddr1   = 5'd17;
    readAddr2   = 5'd17;
    #1;
    check("bypass_p1", readData1, 32'hA5A5_A5A5);
    check("bypass_p2", readData2, 32'hA5A5_A5A5);
    step();
    writeEnable = 1'b0;
    #1;
    check("persist_p1", readData1, 32'hA5A5_A5A5);
    check("persist_p2", readData2, 32'hA5A5_A5A5);

    // Write r5 while reading r9/r17: no interaction
    writeEnable = 1'b1;
    writeAddr   = 5'd5;
    writeData   = 32'h0000_0011;
    readAddr1   = 5'd9;
    readAddr2   = 5'd17;
    #1;
    check("distinct_p1", readData1, 32'hDEAD_BEEF);
    check("distinct_p2", readData2, 32'hA5A5_A5A5);
    step();
    writeEnable = 1'b0;
    for (int i = 0; i < 5; i++) step();
    readAddr1 = 5'd5;
    readAddr2 = 5'd9;
    #1;
    check("hold_r5", readData1, 32'h0000_0011);
    check("hold_r9", readData2, 32'hDEAD_BEEF);

    // Mid-operation reset: r31 written, then reset with an in-flight write
    writeEnable = 1'b1;
    writeAddr   = 5'd31;
    writeData   = 32'h0000_0055;
    step();
    writeEnable = 1'b0;
    readAddr1   = 5'd31;
    readAddr2   = 5'd30;
    #1;
    check("r31_before_reset", readData1, 32'h0000_0055);
    reset       = 1'b1;
    writeEnable = 1'b1;
    writeAddr   = 5'd30;
    writeData   = 32'h0000_0077;
    #1;
    check("in_reset_ready", {31'b0, ready}, 32'h0);
    check("in_reset_rd1", readData1, 32'h0);
    check("in_reset_rd2", readData2, 32'h0);
    step();
    reset       = 1'b0;
    writeEnable = 1'b0;
    count_sweep(1'b0, lows);
    check("resweep_low_cycles", lows, 32);
    check("ready_after_resweep", {31'b0, ready}, 32'h1);
    readAddr1 = 5'd31;
    readAddr2 = 5'd30;
    #1;
    check("r31_after_reset", readData1, 32'h0);
    check("r30_dropped_write", readData2, 32'h0);
    readAddr1 = 5'd9;
    readAddr2 = 5'd17;
    #1;
    check("r9_after_reset", readData1, 32'h0);
    check("r17_after_reset", readData2, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
